// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared state encoding and mode constants for reg_dump_ctrl
package reg_dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DUMP_RD   = 3'd1,
        S_DUMP_OUT0 = 3'd2,
        S_DUMP_OUT1 = 3'd3,
        S_LOAD      = 3'd4,
        S_DONE      = 3'd5,
        S_CSUM      = 3'd6
    } dumpState_t;

    localparam logic MODE_DUMP = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

endpackage

// File: rtl/reg_dump_if.sv
// rtl/reg_dump_if.sv - register file port plus load/dump word streams
interface reg_dump_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] readReg1;
    logic [ADDR_W-1:0] readReg2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              regWrite;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;

    modport master (
        output readReg1, readReg2, writeReg, writeData, regWrite,
        output in_ready, out_valid, out_data, out_idx,
        input  readData1, readData2, in_valid, in_data, out_ready
    );

    modport slave (
        input  readReg1, readReg2, writeReg, writeData, regWrite,
        input  in_ready, out_valid, out_data, out_idx,
        output readData1, readData2, in_valid, in_data, out_ready
    );
endinterface

// File: rtl/reg_dump_ctrl.sv
// rtl/reg_dump_ctrl.sv - bulk load/dump sequencer for the CPU register file
// Optional trailing XOR checksum word on dumps: define REG_DUMP_CSUM_EN.
module reg_dump_ctrl
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mode,
    output logic       busy,
    output logic       done,
    reg_dump_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NUM_REGS / 2 - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_REGS - 1);

    dumpState_t        state, stateNext;
    logic [ADDR_W-1:0] pairCnt;
    logic [ADDR_W-1:0] wordCnt;
    logic [DATA_W-1:0] buf0, buf1;
    logic [ADDR_W-1:0] pairBase;
    logic              lastPair, lastWord;
`ifdef REG_DUMP_CSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    assign pairBase = {pairCnt[ADDR_W-2:0], 1'b0};
    assign lastPair = (pairCnt == LAST_PAIR);
    assign lastWord = (wordCnt == LAST_WORD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            pairCnt <= '0;
            wordCnt <= '0;
            buf0    <= '0;
            buf1    <= '0;
`ifdef REG_DUMP_CSUM_EN
            csum    <= '0;
`endif
        end else begin
            state <= stateNext;
            case (state)
                S_IDLE: if (start) begin
                    pairCnt <= '0;
                    wordCnt <= '0;
`ifdef REG_DUMP_CSUM_EN
                    csum    <= '0;
`endif
                end
                // Register file reads are combinational, so data is captured in the address cycle.
                S_DUMP_RD: begin
                    buf0 <= bus.readData1;
                    buf1 <= bus.readData2;
                end
                S_DUMP_OUT0: begin
`ifdef REG_DUMP_CSUM_EN
                    if (bus.out_ready) csum <= csum ^ buf0;
`endif
                end
                S_DUMP_OUT1: begin
                    if (bus.out_ready && !lastPair) pairCnt <= pairCnt + ADDR_W'(1);
`ifdef REG_DUMP_CSUM_EN
                    if (bus.out_ready) csum <= csum ^ buf1;
`endif
                end
                S_LOAD: if (bus.in_valid && !lastWord) wordCnt <= wordCnt + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:      if (start) stateNext = (mode == MODE_LOAD) ? S_LOAD : S_DUMP_RD;
            S_DUMP_RD:   stateNext = S_DUMP_OUT0;
            S_DUMP_OUT0: if (bus.out_ready) stateNext = S_DUMP_OUT1;
            S_DUMP_OUT1: if (bus.out_ready) begin
`ifdef REG_DUMP_CSUM_EN
                stateNext = lastPair ? S_CSUM : S_DUMP_RD;
`else
                stateNext = lastPair ? S_DONE : S_DUMP_RD;
`endif
            end
`ifdef REG_DUMP_CSUM_EN
            S_CSUM:      if (bus.out_ready) stateNext = S_DONE;
`endif
            S_LOAD:      if (bus.in_valid && lastWord) stateNext = S_DONE;
            S_DONE:      stateNext = S_IDLE;
            default:     stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        bus.readReg1  = '0;
        bus.readReg2  = '0;
        bus.writeReg  = '0;
        bus.writeData = '0;
        bus.regWrite  = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_idx   = '0;
        case (state)
            S_DUMP_RD: begin
                bus.readReg1 = pairBase;
                bus.readReg2 = pairBase | ADDR_W'(1);
            end
            S_DUMP_OUT0: begin
                bus.out_valid = 1'b1;
                bus.out_data  = buf0;
                bus.out_idx   = pairBase;
            end
            S_DUMP_OUT1: begin
                bus.out_valid = 1'b1;
                bus.out_data  = buf1;
                bus.out_idx   = pairBase | ADDR_W'(1);
            end
`ifdef REG_DUMP_CSUM_EN
            S_CSUM: begin
                bus.out_valid = 1'b1;
                bus.out_data  = csum;
            end
`endif
            S_LOAD: begin
                bus.in_ready  = 1'b1;
                bus.regWrite  = bus.in_valid;
                bus.writeReg  = wordCnt;
                bus.writeData = bus.in_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb/tb_reg_dump_ctrl.sv - scoreboard bench for reg_dump_ctrl with a register file model
module tb_reg_dump_ctrl;

    localparam int NR = 32;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic busy, done;

    reg_dump_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    reg_dump_ctrl #(.NUM_REGS(NR), .ADDR_W(5), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file: combinational reads, register 0 hardwired to zero.
    logic [31:0] rf [NR];
    initial for (int i = 0; i < NR; i++) rf[i] = '0;
    always @(posedge clk)
        if (bus.regWrite === 1'b1 && bus.writeReg != 5'd0) rf[bus.writeReg] <= bus.writeData;
    assign bus.readData1 = rf[bus.readReg1];
    assign bus.readData2 = rf[bus.readReg2];

    int total = 0;
    int bad = 0;
    ent_t outQ[$];
    ent_t wrQ[$];
    logic [31:0] model [NR];
    logic [31:0] words [NR];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops scoreboards on handshakes, checks hold under stall and done width.
    logic        prevStall = 1'b0;
    logic        prevDone = 1'b0;
    logic [4:0]  heldIdx;
    logic [31:0] heldData;
    always @(negedge clk) begin
        ent_t e;
        if (bus.regWrite === 1'b1) begin
            check("wr_on_handshake", {bus.in_valid, bus.in_ready}, 2'b11);
            if (wrQ.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                e = wrQ.pop_front();
                check("wr_idx", bus.writeReg, e.idx);
                check("wr_data", bus.writeData, e.data);
            end
        end
        if (prevStall) check("out_hold", {bus.out_valid, bus.out_idx, bus.out_data}, {1'b1, heldIdx, heldData});
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (outQ.size() == 0) check("out_unexpected", 1, 0);
            else begin
                e = outQ.pop_front();
                check("out_idx", bus.out_idx, e.idx);
                check("out_data", bus.out_data, e.data);
            end
        end
        prevStall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
        heldIdx   = bus.out_idx;
        heldData  = bus.out_data;
        if (done === 1'b1) check("done_width", prevDone, 0);
        prevDone = (done === 1'b1);
    end

    task automatic pulseStart(input logic m);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_ctrl"}, {busy, done, bus.regWrite, bus.in_ready, bus.out_valid}, 0);
        check({tag, "_addr"}, {bus.readReg1, bus.readReg2, bus.writeReg, bus.out_idx}, 0);
        check({tag, "_data"}, {bus.writeData, bus.out_data}, 0);
    endtask

    task automatic doLoad(input bit gaps, input bit injectStart, input int expCycles);
        int idx = 0;
        int cycles = 0;
        bit seen = 0;
        for (int i = 0; i < NR; i++) begin
            wrQ.push_back('{idx: 5'(i), data: words[i]});
            model[i] = (i == 0) ? 32'd0 : words[i];
        end
        pulseStart(1'b1);
        while (!seen && cycles < 400) begin
            bus.in_valid = (idx < NR) ? (gaps ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
            bus.in_data  = (idx < NR) ? words[idx] : $urandom;
            start = injectStart && (cycles == 5);
            mode  = 1'b0;
            @(negedge clk);
            cycles++;
            if (bus.in_valid && bus.in_ready) idx++;
            if (done) seen = 1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
        check("load_timeout", seen, 1);
        if (expCycles > 0) check("load_cycles", cycles, expCycles);
        check("load_wrq_empty", wrQ.size(), 0);
        @(negedge clk);
        check("load_busy_after", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic pushDump();
        logic [31:0] x = '0;
        for (int i = 0; i < NR; i++) begin
            outQ.push_back('{idx: 5'(i), data: model[i]});
            x ^= model[i];
        end
`ifdef REG_DUMP_CSUM_EN
        outQ.push_back('{idx: 5'd0, data: x});
`endif
    endtask

    task automatic doDump(input int rmode, input int expCycles);
        int cycles = 0;
        bit seen = 0;
        pushDump();
        bus.out_ready = 1'b1;
        pulseStart(1'b0);
        while (!seen && cycles < 600) begin
            case (rmode)
                1:       bus.out_ready = ~bus.out_ready;
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b1;
            endcase
            @(negedge clk);
            cycles++;
            if (done) seen = 1;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        check("dump_timeout", seen, 1);
        if (expCycles > 0) check("dump_cycles", cycles, expCycles);
        check("dump_outq_empty", outQ.size(), 0);
        @(negedge clk);
        check("dump_busy_after", busy, 0);
        @(posedge clk); #1;
    endtask

    int dumpCycles;

    initial begin
        bit hit;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = '0;
`ifdef REG_DUMP_CSUM_EN
        dumpCycles = NR * 3 / 2 + 2;
`else
        dumpCycles = NR * 3 / 2 + 1;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkIdleOutputs("reset");
        @(posedge clk); #1;

        for (int i = 0; i < NR; i++) words[i] = 32'(i) * 32'h01010101;
        doLoad(0, 0, NR + 1);
        doDump(0, dumpCycles);

        for (int i = 0; i < NR; i++) words[i] = $urandom;
        words[21] = 32'hFFFF0000;
        words[10] = 32'h0000FFFF;
        doLoad(1, 1, 0);
        doDump(1, 0);
        doDump(2, 0);

        pushDump();
        bus.out_ready = 1'b1;
        pulseStart(1'b0);
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_idx == 5'd14) hit = 1;
        end
        check("abort_reach_pair7", hit, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checkIdleOutputs("abort");
        outQ.delete();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        @(posedge clk); #1;
        doDump(0, dumpCycles);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_dump_ctrl.md
# reg_dump_ctrl

Sequencer that drives the register file's read and write ports to bulk-load all registers from an input word stream, or dump all registers to an output word stream. Sits between the CPU register file (`Registers`) and a debug/test host, acting as the initiator on the register file's `readReg1/readReg2/writeReg/writeData/regWrite` interface. Used for bring-up, for checkpointing state before a test program, and for reading back results afterwards.

## Interface
- `NUM_REGS`, 32, registers swept; even, ≤ 2^ADDR_W
- `ADDR_W`, 5, register index width
- `DATA_W`, 32, word width
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse; sampled only in IDLE
- `mode`  in  1  0 = dump, 1 = load; captured with `start`
- `busy`  out  1  high from the cycle after `start` until DONE exits
- `done`  out  1  one-cycle pulse on completion
- `readReg1`, `readReg2`  out  ADDR_W  register file read addresses
- `readData1`, `readData2`  in  DATA_W  combinational read data
- `writeReg`  out  ADDR_W; `writeData`  out  DATA_W; `regWrite`  out  1
- `in_valid`  in  1; `in_ready`  out  1; `in_data`  in  DATA_W  (load stream)
- `out_valid`  out  1; `out_ready`  in  1; `out_data`  out  DATA_W; `out_idx`  out  ADDR_W  (dump stream)

## Operation
- States: IDLE, DUMP_RD, DUMP_OUT0, DUMP_OUT1, LOAD, DONE (plus CSUM when `REG_DUMP_CSUM_EN` is defined).
- IDLE: on `start`: `mode=0` goes to DUMP_RD, `mode=1` goes to LOAD. Pair counter `p` is set to 0 and the checksum to 0.
- DUMP_RD:
  - Drive `readReg1=2p` and `readReg2=2p+1`.
  - Latch `readData1/2` into a two-word buffer.
  - Go to DUMP_OUT0.
- DUMP_OUT0:
  - `out_valid=1`, `out_data=buf0`, `out_idx=2p`.
  - On `out_valid&&out_ready`, go to DUMP_OUT1.
- DUMP_OUT1:
  - Same handshake as DUMP_OUT0 with `buf1` and index `2p+1`.
  - On handshake: if `p==NUM_REGS/2-1`, go to DONE (or CSUM); else `p++` and go to DUMP_RD.
- LOAD:
  - `in_ready=1`.
  - On `in_valid&&in_ready`: `regWrite=1`, `writeReg=w`, `writeData=in_data` (same cycle, combinational from the stream), then `w++`.
  - After the word with `w==NUM_REGS-1`, go to DONE.
- DONE: `done=1` for one cycle, then go to IDLE.
- `out_data`/`out_idx` hold stable while `out_valid` is high and `out_ready` is low.
- `regWrite` is never high outside LOAD. `in_ready` is 0 outside LOAD. `out_valid` is 0 outside DUMP_OUT*/CSUM.
- Register 0 is written like any other register; whether it retains the value is the register file's behaviour, not this block's.
- Counters wrap never occurs: termination is by explicit compare, and the counter width is ADDR_W.

## Timing
- Reset values:
  - `busy=0`, `done=0`, `regWrite=0`, `in_ready=0`, `out_valid=0`.
  - All address and data outputs 0; state IDLE.
- `reset` mid-operation aborts in the next cycle with no `done` pulse. Partially loaded registers keep their values.
- `start` while busy is ignored.
- Dump with `out_ready` held high: 3 cycles per pair, so `NUM_REGS*3/2` cycles + 1 (DONE). That is 49 cycles for 32 registers.
- Load with `in_valid` held high: 1 word/cycle, so `NUM_REGS` + 1 cycles.
- Dump read latency: address driven in DUMP_RD, data captured at the end of that same cycle. This relies on the register file's combinational read.

## Configuration
- `REG_DUMP_CSUM_EN` defined:
  - The dump keeps a running XOR of all emitted words.
  - After the last register, CSUM state emits one extra word, `out_data=xor`, `out_idx=0`, with the same handshake, then goes to DONE.
  - Load is unaffected.
- Not defined: no CSUM state; the dump emits exactly `NUM_REGS` words.

## Structure
- Shared package `reg_dump_pkg`: state encoding (3-bit), `MODE_DUMP=0`, `MODE_LOAD=1`.
- No sub-module is needed; the two-word buffer is two registers inside the block.

## Test plan
- Load then dump:
  - Load stream word i = i×0x01010101.
  - Dump with `out_ready=1`.
  - Required: 32 outputs, `out_idx` 0..31, data matches (reg 0 per register file semantics); `done` 1 cycle.
- Targeted values:
  - Preload reg 21=0xFFFF0000 and reg 10=0x0000FFFF.
  - Dump: idx 10 gives 0x0000FFFF, idx 21 gives 0xFFFF0000.
- Backpressure: toggle `out_ready` every other cycle. Required: `out_data`/`out_idx` stable while stalled, no word lost or duplicated.
- Load gaps: `in_valid` random 50%. Required: `regWrite` pulses only on handshakes, `writeReg` sequential 0..31.
- Abort: `reset` in the middle of the dump at pair 7. Required: all outputs 0 next cycle, no `done`; a fresh `start` dumps from idx 0.
- With `REG_DUMP_CSUM_EN`: the 33rd word equals the XOR of the 32 dumped words.
